de1_soc_qsys_cpu_ocimem_arbiter: RTL and testbench

DE1_SOC_QSYS_CPU_OCIMEM_ARBITER -- requirements
Module: de1_soc_qsys_cpu_ocimem_arbiter

---
 rtl/de1_soc_qsys_cpu_ocimem_pkg.sv | 27 ++
 rtl/de1_soc_qsys_cpu_ocimem_jtag_cmd.sv | 82 ++++++++
 rtl/de1_soc_qsys_cpu_ocimem_arbiter.sv | 128 ++++++++++++
 tb/tb_de1_soc_qsys_cpu_ocimem_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/de1_soc_qsys_cpu_ocimem_pkg.sv
// Shared types for the OCI debug RAM arbiter: FSM states, grant/op encodings, jdo field offsets.
// Pure declarations; no logic, no latency.
package de1_soc_qsys_cpu_ocimem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_JTAG_RD_WAIT = 2'd1,
    ST_AV_RD_WAIT   = 2'd2,
    ST_AV_RD_DONE   = 2'd3
  } state_e;

  typedef enum logic {
    GNT_JTAG = 1'b0,
    GNT_AV   = 1'b1
  } gnt_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_WDATA_MSB = 34;

endpackage

// File: rtl/de1_soc_qsys_cpu_ocimem_jtag_cmd.sv
// JTAG side: auto-incrementing address pointer, single-entry command latch, sticky overrun flag.
// Command registered 1 cycle after its pulse; pulses arriving while a command is pending are dropped.
module de1_soc_qsys_cpu_ocimem_jtag_cmd
  import de1_soc_qsys_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo_i,
  input  logic              take_addr_i,
  input  logic              take_wr_i,
  input  logic              take_rd_i,
  input  logic              cmd_done_i,
  output logic              pending_o,
  output op_e               op_o,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [DATA_W-1:0] cmd_wdata_o,
  output logic              overrun_o
);

  logic [ADDR_W-1:0] jtag_addr_q, jtag_addr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
  op_e               op_q, op_d;
  logic              pending_q, pending_d;
  logic              overrun_q, overrun_d;
  logic [ADDR_W-1:0] addr_base;
  logic              cmd_pulse;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo_i[JDO_W-1:JDO_WDATA_MSB+1], jdo_i[JDO_WDATA_LSB-1:0]};

  always_comb begin
    // An address load in the same cycle as a command is applied before the command.
    addr_base   = take_addr_i ? jdo_i[JDO_ADDR_LSB +: ADDR_W] : jtag_addr_q;
    cmd_pulse   = take_wr_i | take_rd_i;
    jtag_addr_d = addr_base;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    op_d        = op_q;
    pending_d   = pending_q & ~cmd_done_i;
    overrun_d   = overrun_q & ~take_addr_i;
    if (cmd_pulse) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d   = 1'b1;
        op_d        = take_wr_i ? OP_WR : OP_RD;
        cmd_wdata_d = jdo_i[JDO_WDATA_LSB +: DATA_W];
        cmd_addr_d  = addr_base;
        jtag_addr_d = addr_base + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jtag_addr_q <= '0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      op_q        <= OP_RD;
      pending_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      jtag_addr_q <= jtag_addr_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      op_q        <= op_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
    end
  end

  assign pending_o   = pending_q;
  assign op_o        = op_q;
  assign cmd_addr_o  = cmd_addr_q;
  assign cmd_wdata_o = cmd_wdata_q;
  assign overrun_o   = overrun_q;

endmodule

// File: rtl/de1_soc_qsys_cpu_ocimem_arbiter.sv
// Arbitrates the OCI debug RAM between JTAG and the CPU slave port, alternating on contention.
// Writes take 1 cycle, AV reads 3 cycles (waitrequest low in the 3rd), JTAG reads update MonDReg 2 cycles after grant.
module de1_soc_qsys_cpu_ocimem_arbiter
  import de1_soc_qsys_cpu_ocimem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [DATA_W-1:0] MonDReg,
  output logic              mon_ready,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [DATA_W-1:0] avs_writedata,
  output logic [DATA_W-1:0] avs_readdata,
  output logic              avs_waitrequest,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  state_e            state_q, state_d;
  gnt_e              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] mon_dreg_q, avs_readdata_q;
  logic              jtag_pending, jtag_done;
  op_e               jtag_op;
  logic [ADDR_W-1:0] jtag_cmd_addr;
  logic [DATA_W-1:0] jtag_wdata;
  logic              av_req, av_accept;

  de1_soc_qsys_cpu_ocimem_jtag_cmd #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_jtag_cmd (
    .clk         (clk),
    .reset_n     (reset_n),
    .jdo_i       (jdo),
    .take_addr_i (take_action_ocimem_a),
    .take_wr_i   (take_action_ocimem_b),
    .take_rd_i   (take_no_action_ocimem_a),
    .cmd_done_i  (jtag_done),
    .pending_o   (jtag_pending),
    .op_o        (jtag_op),
    .cmd_addr_o  (jtag_cmd_addr),
    .cmd_wdata_o (jtag_wdata),
    .overrun_o   (jtag_overrun)
  );

  assign av_req = avs_read | avs_write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ram_en       = 1'b0;
    ram_we       = 1'b0;
    ram_addr     = '0;
    ram_wdata    = '0;
    jtag_done    = 1'b0;
    av_accept    = 1'b0;
    // Grants are gated by reset_n so the RAM sees no access while reset is held.
    case (state_q)
      ST_IDLE: begin
        if (reset_n && jtag_pending && (!av_req || last_grant_q == GNT_AV)) begin
          last_grant_d = GNT_JTAG;
          ram_en       = 1'b1;
          ram_addr     = jtag_cmd_addr;
          if (jtag_op == OP_WR) begin
            ram_we    = 1'b1;
            ram_wdata = jtag_wdata;
            jtag_done = 1'b1;
          end else begin
            state_d = ST_JTAG_RD_WAIT;
          end
        end else if (reset_n && av_req) begin
          last_grant_d = GNT_AV;
          ram_en       = 1'b1;
          ram_addr     = avs_address;
          if (avs_write) begin
            ram_we    = 1'b1;
            ram_wdata = avs_writedata;
            av_accept = 1'b1;
          end else begin
            state_d = ST_AV_RD_WAIT;
          end
        end
      end
      ST_JTAG_RD_WAIT: begin
        jtag_done = 1'b1;
        state_d   = ST_IDLE;
      end
      ST_AV_RD_WAIT: state_d = ST_AV_RD_DONE;
      ST_AV_RD_DONE: begin
        av_accept = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GNT_AV;
      mon_dreg_q     <= '0;
      avs_readdata_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      if (state_q == ST_JTAG_RD_WAIT) mon_dreg_q <= ram_rdata;
      if (state_q == ST_AV_RD_WAIT) avs_readdata_q <= ram_rdata;
    end
  end

  assign MonDReg         = mon_dreg_q;
  assign avs_readdata    = avs_readdata_q;
  assign mon_ready       = ~jtag_pending;
  assign avs_waitrequest = ~reset_n | (av_req & ~av_accept);

endmodule

// File: tb/tb_de1_soc_qsys_cpu_ocimem_arbiter.sv
// Scoreboard bench for the OCI debug RAM arbiter: expected RAM accesses and AV read data are queued
// by the stimulus and checked by a negedge monitor against a behavioural RAM.
module tb_de1_soc_qsys_cpu_ocimem_arbiter;

  typedef struct packed {
    logic [7:0]  addr;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_a, take_b, take_rd;
  logic [31:0] MonDReg;
  logic        mon_ready, jtag_overrun;
  logic [7:0]  avs_address;
  logic        avs_read, avs_write;
  logic [31:0] avs_writedata, avs_readdata;
  logic        avs_waitrequest;
  logic [7:0]  ram_addr;
  logic        ram_en, ram_we;
  logic [31:0] ram_wdata, ram_rdata;

  logic [31:0] mem [256];
  logic        mem_init = 1'b0;

  acc_t        exp_q[$];
  logic [31:0] av_q[$];
  int          total = 0;
  int          bad = 0;

  de1_soc_qsys_cpu_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_a),
    .take_action_ocimem_b    (take_b),
    .take_no_action_ocimem_a (take_rd),
    .MonDReg                 (MonDReg),
    .mon_ready               (mon_ready),
    .jtag_overrun            (jtag_overrun),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .ram_addr                (ram_addr),
    .ram_en                  (ram_en),
    .ram_we                  (ram_we),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural RAM, 1-cycle read latency; word i starts as 0xA50000ii.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem_init  <= 1'b1;
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata     <= mem[ram_addr];
    end
  end

  // Monitor: every RAM access and every completed AV read is popped and compared.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (ram_en) begin
        acc_t e;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL ram_unexpected: got addr=%h we=%b wdata=%h required no access", ram_addr, ram_we, ram_wdata);
        end else begin
          e = exp_q.pop_front();
          if (ram_addr !== e.addr || ram_we !== e.we || (e.we && ram_wdata !== e.wdata)) begin
            bad++;
            $display("FAIL ram_access: got addr=%h we=%b wdata=%h required addr=%h we=%b wdata=%h",
                     ram_addr, ram_we, ram_wdata, e.addr, e.we, e.wdata);
          end
        end
      end
      if (avs_read && !avs_waitrequest) begin
        logic [31:0] d;
        total++;
        if (av_q.size() == 0) begin
          bad++;
          $display("FAIL av_rd_unexpected: got readdata=%h required no completion", avs_readdata);
        end else begin
          d = av_q.pop_front();
          if (avs_readdata !== d) begin
            bad++;
            $display("FAIL av_readdata: got %h required %h", avs_readdata, d);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h required %h", nm, act, expv);
    end
  endtask

  task automatic push(input logic [7:0] a, input logic we, input logic [31:0] d);
    exp_q.push_back({a, we, d});
  endtask

  task automatic jload(input logic [7:0] a);
    jdo = '0;
    jdo[24:17] = a;
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
  endtask

  task automatic jwrite(input logic [31:0] d);
    jdo = '0;
    jdo[34:3] = d;
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
  endtask

  task automatic jread();
    take_rd = 1'b1;
    tick();
    take_rd = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!mon_ready && n < 20) begin
      tick();
      n++;
    end
    if (!mon_ready) begin
      total++;
      bad++;
      $display("FAIL mon_ready_timeout: got pending after %0d cycles required ready", n);
    end
  endtask

  task automatic av_write(input logic [7:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(negedge clk);
    chk("av_wr_waitrequest", 32'(avs_waitrequest), 32'd0);
    tick();
    avs_write = 1'b0;
  endtask

  task automatic av_read(input logic [7:0] a, input int lat);
    int n = 0;
    avs_address = a;
    avs_read    = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (avs_waitrequest && n < 20);
    chk("av_rd_latency", 32'(n), 32'(lat));
    tick();
    avs_read = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int jc;
    reset_n = 1'b0;
    jdo = '0; take_a = 1'b0; take_b = 1'b0; take_rd = 1'b0;
    avs_address = '0; avs_read = 1'b1; avs_write = 1'b0; avs_writedata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_waitrequest", 32'(avs_waitrequest), 32'd1);
    chk("rst_ram_en", 32'(ram_en), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_mondreg", MonDReg, 32'd0);
    chk("rst_readdata", avs_readdata, 32'd0);
    chk("rst_mon_ready", 32'(mon_ready), 32'd1);
    chk("rst_overrun", 32'(jtag_overrun), 32'd0);
    avs_read = 1'b0;
    reset_n  = 1'b1;
    tick();

    // Write then read back through the pointer.
    jload(8'h10);
    push(8'h10, 1'b1, 32'hDEADBEEF);
    jwrite(32'hDEADBEEF);
    wait_ready(n);
    jload(8'h10);
    push(8'h10, 1'b0, 32'h0);
    jread();
    wait_ready(n);
    chk("jtag_rd_latency", 32'(n), 32'd2);
    chk("mondreg_10", MonDReg, 32'hDEADBEEF);
    push(8'h11, 1'b0, 32'h0);
    jread();
    wait_ready(n);
    chk("mondreg_11", MonDReg, 32'hA500_0011);

    // Pointer wrap.
    jload(8'hFF);
    push(8'hFF, 1'b0, 32'h0);
    jread();
    wait_ready(n);
    chk("mondreg_ff", MonDReg, 32'hA500_00FF);
    push(8'h00, 1'b0, 32'h0);
    jread();
    wait_ready(n);
    chk("mondreg_wrap", MonDReg, 32'hA500_0000);

    // Overrun: second write while the first is pending is dropped.
    jload(8'h30);
    push(8'h30, 1'b1, 32'h1111_1111);
    jwrite(32'h1111_1111);
    jwrite(32'h2222_2222);
    wait_ready(n);
    chk("overrun_set", 32'(jtag_overrun), 32'd1);
    push(8'h31, 1'b0, 32'h0);
    jread();
    wait_ready(n);
    chk("mondreg_31", MonDReg, 32'hA500_0031);
    chk("overrun_sticky", 32'(jtag_overrun), 32'd1);
    jload(8'h40);
    chk("overrun_clear", 32'(jtag_overrun), 32'd0);

    // Contention: after an AV grant, JTAG wins first.
    push(8'h50, 1'b1, 32'hCAFE_F00D);
    av_write(8'h50, 32'hCAFE_F00D);
    jload(8'h60);
    push(8'h60, 1'b0, 32'h0);
    push(8'h20, 1'b0, 32'h0);
    av_q.push_back(32'hA500_0020);
    jread();
    av_read(8'h20, 5);
    wait_ready(n);
    chk("mondreg_60", MonDReg, 32'hA500_0060);
    push(8'h61, 1'b0, 32'h0);
    jread();
    wait_ready(n);
    // Last grant was JTAG, so AV wins this time.
    push(8'h20, 1'b0, 32'h0);
    push(8'h62, 1'b0, 32'h0);
    av_q.push_back(32'hA500_0020);
    jread();
    av_read(8'h20, 3);
    wait_ready(n);
    chk("mondreg_62", MonDReg, 32'hA500_0062);

    // Continuous AV writes interleaved with JTAG reads.
    jload(8'h80);
    push(8'h70, 1'b1, 32'h7777_7777);
    push(8'h80, 1'b0, 32'h0);
    push(8'h70, 1'b1, 32'h7777_7777);
    push(8'h81, 1'b0, 32'h0);
    push(8'h70, 1'b1, 32'h7777_7777);
    push(8'h82, 1'b0, 32'h0);
    push(8'h70, 1'b1, 32'h7777_7777);
    push(8'h70, 1'b1, 32'h7777_7777);
    avs_address = 8'h70;
    avs_writedata = 32'h7777_7777;
    avs_write = 1'b1;
    jc = 0;
    for (int i = 0; i < 11; i++) begin
      if (mon_ready && jc < 3) begin
        take_rd = 1'b1;
        jc++;
      end else begin
        take_rd = 1'b0;
      end
      tick();
    end
    take_rd = 1'b0;
    avs_write = 1'b0;
    wait_ready(n);
    chk("mondreg_82", MonDReg, 32'hA500_0082);
    chk("overrun_mix", 32'(jtag_overrun), 32'd0);

    // Reset in the middle of an AV read.
    push(8'h20, 1'b0, 32'h0);
    avs_address = 8'h20;
    avs_read = 1'b1;
    tick();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_waitrequest", 32'(avs_waitrequest), 32'd1);
    chk("mid_rst_ram_en", 32'(ram_en), 32'd0);
    chk("mid_rst_mondreg", MonDReg, 32'd0);
    chk("mid_rst_readdata", avs_readdata, 32'd0);
    chk("mid_rst_mon_ready", 32'(mon_ready), 32'd1);
    @(negedge clk);
    chk("mid_rst_waitrequest_hold", 32'(avs_waitrequest), 32'd1);
    tick();
    avs_read = 1'b0;
    reset_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_readdata", avs_readdata, 32'd0);
    chk("post_rst_mondreg", MonDReg, 32'd0);
    chk("post_rst_waitrequest", 32'(avs_waitrequest), 32'd0);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("av_q_drained", 32'(av_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
